atm_input_frontend: RTL and testbench

//  Board-side producer for the ATM controller's user-input interface. Takes raw board signals and

---
 rtl/atm_input_frontend.sv | 178 +++++++++++++++++
 tb/tb_atm_input_frontend.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_input_frontend.sv
// atm_input_frontend
// Board-side conditioning for the ATM controller's user inputs. Every raw
// button and switch bit is synchronised and debounced. Menu buttons are encoded
// into one-cycle codes, confirm presses become one-cycle pulses, and the card
// and amount switches are forwarded as registered levels.
// Optional feature: define ATM_KEYCLICK_EN to build the key-click tone counter.
// When the macro is not defined, key_click is tied low.
module atm_input_frontend #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20,
  parameter int CLICK_CYCLES    = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] btn_menu_raw,
  input  logic       btn_confirm_raw,
  input  logic [1:0] sw_card_raw,
  input  logic [3:0] sw_deposit_raw,
  input  logic [2:0] sw_withdraw_raw,
  output logic [1:0] card_input,
  output logic [2:0] menu_input,
  output logic       confirm_btn,
  output logic [3:0] deposit_amount,
  output logic [2:0] withdraw_amount,
  output logic       key_click
);

  // Bit layout of the packed raw vector:
  // [4:0] menu, [5] confirm, [7:6] card, [11:8] deposit, [14:12] withdraw.
  localparam int NumBits = 15;
  localparam logic [CNT_W-1:0] CountLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    MenuOpen   = 1'b0,
    MenuLocked = 1'b1
  } menuState_e;

  logic [NumBits-1:0] rawBits;
  logic [NumBits-1:0] syncMeta_q;
  logic [NumBits-1:0] syncOut_q;
  logic [NumBits-1:0] dbLevel_q;
  logic [NumBits-1:0] dbLevel_d;
  logic [CNT_W-1:0]   dbCount_q [NumBits];
  logic [CNT_W-1:0]   dbCount_d [NumBits];

  logic       confirmPrev_q;
  logic       confirmBtn_q;
  logic       confirmRise_d;
  menuState_e menuState_q;
  logic [2:0] menuInput_q;
  logic [2:0] menuCode_d;
  logic       menuFire_d;
  logic [1:0] cardInput_q;
  logic [3:0] depositAmount_q;
  logic [2:0] withdrawAmount_q;

  assign rawBits = {sw_withdraw_raw, sw_deposit_raw, sw_card_raw,
                    btn_confirm_raw, btn_menu_raw};

  // Two-flop synchroniser bringing every asynchronous board bit into the clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncMeta_q <= '0;
      syncOut_q  <= '0;
    end else begin
      syncMeta_q <= rawBits;
      syncOut_q  <= syncMeta_q;
    end
  end

  // Per-bit debounce: count consecutive disagreeing cycles and flip once the run is long enough
  always_comb begin
    for (int i = 0; i < NumBits; i++) begin
      dbLevel_d[i] = dbLevel_q[i];
      dbCount_d[i] = '0;
      if (syncOut_q[i] != dbLevel_q[i]) begin
        if (dbCount_q[i] == CountLast) begin
          dbLevel_d[i] = ~dbLevel_q[i];
        end else begin
          dbCount_d[i] = dbCount_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounced levels and their run counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbLevel_q <= '0;
      dbCount_q <= '{default: '0};
    end else begin
      dbLevel_q <= dbLevel_d;
      dbCount_q <= dbCount_d;
    end
  end

  // Lowest-index debounced menu bit wins; the others are ignored
  always_comb begin
    menuCode_d = 3'b000;
    for (int i = 4; i >= 0; i--) begin
      if (dbLevel_q[i]) begin
        menuCode_d = 3'(i + 1);
      end
    end
  end

  assign confirmRise_d = dbLevel_q[5] & ~confirmPrev_q;
  assign menuFire_d    = (menuState_q == MenuOpen) && (dbLevel_q[4:0] != 5'b0);

  // Registered level outputs; a debounced card code of 11 is reported as invalid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cardInput_q      <= 2'b00;
      depositAmount_q  <= 4'h0;
      withdrawAmount_q <= 3'h0;
    end else begin
      cardInput_q      <= (dbLevel_q[7:6] == 2'b11) ? 2'b01 : dbLevel_q[7:6];
      depositAmount_q  <= dbLevel_q[11:8];
      withdrawAmount_q <= dbLevel_q[14:12];
    end
  end

  // Confirm edge detector plus the menu OPEN/LOCKED encoder with one-cycle code outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      confirmPrev_q <= 1'b0;
      confirmBtn_q  <= 1'b0;
      menuState_q   <= MenuOpen;
      menuInput_q   <= 3'b000;
    end else begin
      confirmPrev_q <= dbLevel_q[5];
      confirmBtn_q  <= confirmRise_d;
      menuInput_q   <= 3'b000;
      case (menuState_q)
        MenuOpen: begin
          if (menuFire_d) begin
            menuInput_q <= menuCode_d;
            menuState_q <= MenuLocked;
          end
        end
        MenuLocked: begin
          if (dbLevel_q[4:0] == 5'b0) begin
            menuState_q <= MenuOpen;
          end
        end
        default: menuState_q <= MenuOpen;
      endcase
    end
  end

  assign card_input      = cardInput_q;
  assign menu_input      = menuInput_q;
  assign confirm_btn     = confirmBtn_q;
  assign deposit_amount  = depositAmount_q;
  assign withdraw_amount = withdrawAmount_q;

`ifdef ATM_KEYCLICK_EN
  localparam int ClickW = $clog2(CLICK_CYCLES + 1);

  logic [ClickW-1:0] clickCount_q;

  // Each key event reloads the tone length, otherwise the tone counts down to silence
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clickCount_q <= '0;
    end else if (menuFire_d || confirmRise_d) begin
      clickCount_q <= ClickW'(CLICK_CYCLES);
    end else if (clickCount_q != '0) begin
      clickCount_q <= clickCount_q - ClickW'(1);
    end
  end

  assign key_click = (clickCount_q != '0);
`else
  assign key_click = 1'b0;
`endif

endmodule

// File: tb/tb_atm_input_frontend.sv
// tb_atm_input_frontend
// Self-checking bench for atm_input_frontend. It checks a table of switch
// levels and hand-written sequences for the multi-cycle corner cases. It also
// runs randomized stimulus against a window-based reference model of the
// debounce, encode and click rules. Define ATM_KEYCLICK_EN for the key-click build.
module tb_atm_input_frontend;

  localparam int Deb     = 4;
  localparam int Click   = 3;
  localparam int NumBits = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] btnMenu = 5'b0;
  logic       btnConfirm = 1'b0;
  logic [1:0] swCard = 2'b0;
  logic [3:0] swDeposit = 4'b0;
  logic [2:0] swWithdraw = 3'b0;

  logic [1:0] cardInput;
  logic [2:0] menuInput;
  logic       confirmBtn;
  logic [3:0] depositAmount;
  logic [2:0] withdrawAmount;
  logic       keyClick;

  atm_input_frontend #(
    .DEBOUNCE_CYCLES(Deb),
    .CNT_W(20),
    .CLICK_CYCLES(Click)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_menu_raw(btnMenu),
    .btn_confirm_raw(btnConfirm),
    .sw_card_raw(swCard),
    .sw_deposit_raw(swDeposit),
    .sw_withdraw_raw(swWithdraw),
    .card_input(cardInput),
    .menu_input(menuInput),
    .confirm_btn(confirmBtn),
    .deposit_amount(depositAmount),
    .withdraw_amount(withdrawAmount),
    .key_click(keyClick)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state: raw samples per edge, debounced levels, menu lock, click time left
  logic [NumBits-1:0] hist[$];
  logic [NumBits-1:0] lvl;
  logic [NumBits-1:0] lvlPrev;
  bit                 locked;
  int                 clickLeft;
  logic [13:0]        expVec;

  // Per-window observations used by the hand-written sequences
  int         confPulses;
  int         menuPulses;
  int         clickCycles;
  int         firstConf;
  int         firstMenu;
  logic [2:0] lastMenu;

  typedef struct {
    logic [1:0] card;
    logic [3:0] dep;
    logic [2:0] wd;
    logic [1:0] expCard;
    logic [3:0] expDep;
    logic [2:0] expWd;
  } levelVec_t;

  levelVec_t levelTable[6];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] menu, input logic conf, input logic [1:0] card,
                               input logic [3:0] dep, input logic [2:0] wd);
    btnMenu    = menu;
    btnConfirm = conf;
    swCard     = card;
    swDeposit  = dep;
    swWithdraw = wd;
  endtask

  function automatic void modelReset();
    hist.delete();
    for (int i = 0; i < Deb + 1; i++) hist.push_back('0);
    lvl       = '0;
    lvlPrev   = '0;
    locked    = 1'b0;
    clickLeft = 0;
    expVec    = '0;
  endfunction

  // Outputs after edge k follow the levels after edge k-1. A level flips at
  // edge k when the raw values applied at edges k-Deb-1 .. k-2 (the values
  // seen behind the two synchroniser stages) all disagree with it.
  task automatic modelStep();
    logic [NumBits-1:0] raw;
    logic [NumBits-1:0] nextLvl;
    logic [1:0]         c;
    logic               cf;
    logic [2:0]         m;
    logic               kc;
    bit                 allDiff;
    if (!rst_n) begin
      modelReset();
      return;
    end
    raw = {swWithdraw, swDeposit, swCard, btnConfirm, btnMenu};
    c  = (lvl[7:6] == 2'b11) ? 2'b01 : lvl[7:6];
    cf = lvl[5] & ~lvlPrev[5];
    m  = 3'b000;
    if (!locked) begin
      if (lvl[4:0] != 5'b0) begin
        for (int i = 0; i < 5; i++) if (lvl[i] && m == 3'b000) m = 3'(i + 1);
        locked = 1'b1;
      end
    end else if (lvl[4:0] == 5'b0) begin
      locked = 1'b0;
    end
    if (m != 3'b000 || cf) clickLeft = Click;
    else if (clickLeft > 0) clickLeft--;
`ifdef ATM_KEYCLICK_EN
    kc = (clickLeft != 0);
`else
    kc = 1'b0;
`endif
    expVec = {c, m, cf, lvl[11:8], lvl[14:12], kc};
    hist.push_back(raw);
    while (hist.size() > Deb + 2) void'(hist.pop_front());
    nextLvl = lvl;
    for (int b = 0; b < NumBits; b++) begin
      allDiff = 1'b1;
      for (int j = 0; j < Deb; j++) if (hist[j][b] == lvl[b]) allDiff = 1'b0;
      if (allDiff) nextLvl[b] = ~lvl[b];
    end
    lvlPrev = lvl;
    lvl     = nextLvl;
  endtask

  task automatic cycle();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("modelCompare",
                {cardInput, menuInput, confirmBtn, depositAmount, withdrawAmount, keyClick},
                expVec);
  endtask

  task automatic runWatch(input int n);
    confPulses  = 0;
    menuPulses  = 0;
    clickCycles = 0;
    firstConf   = -1;
    firstMenu   = -1;
    lastMenu    = 3'b000;
    for (int i = 1; i <= n; i++) begin
      cycle();
      if (confirmBtn) begin
        confPulses++;
        if (firstConf < 0) firstConf = i;
      end
      if (menuInput != 3'b000) begin
        menuPulses++;
        lastMenu = menuInput;
        if (firstMenu < 0) firstMenu = i;
      end
      if (keyClick) clickCycles++;
    end
  endtask

  // Hard time limit so the run always ends with a summary
  initial begin
    #2_000_000;
    failures++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Main test sequence
  initial begin
    int firstCard;
    int firstDep;
    int depBad;
    int bounceTotal;
    int preReset;
    int expClick;
`ifdef ATM_KEYCLICK_EN
    expClick = Click;
`else
    expClick = 0;
`endif

    levelTable[0] = '{2'b00, 4'h0, 3'h0, 2'b00, 4'h0, 3'h0};
    levelTable[1] = '{2'b01, 4'h5, 3'h2, 2'b01, 4'h5, 3'h2};
    levelTable[2] = '{2'b10, 4'hA, 3'h5, 2'b10, 4'hA, 3'h5};
    levelTable[3] = '{2'b11, 4'hF, 3'h7, 2'b01, 4'hF, 3'h7};
    levelTable[4] = '{2'b10, 4'h3, 3'h1, 2'b10, 4'h3, 3'h1};
    levelTable[5] = '{2'b00, 4'h8, 3'h4, 2'b00, 4'h8, 3'h4};

    modelReset();

    // Reset with every raw input high
    applyStimulus(5'h1F, 1'b1, 2'b11, 4'hF, 3'h7);
    rst_n = 1'b0;
    cycle();
    cycle();
    checkOutput("resetOutputs",
                {cardInput, menuInput, confirmBtn, depositAmount, withdrawAmount, keyClick}, 0);
    rst_n = 1'b1;
    firstCard = -1;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      if (firstCard < 0 && cardInput == 2'b01) firstCard = i;
    end
    checkOutput("resetReleaseCardLatency", firstCard, 7);
    applyStimulus(5'h00, 1'b0, 2'b00, 4'h0, 3'h0);
    runWatch(12);

    // Table of steady switch levels
    for (int t = 0; t < 6; t++) begin
      applyStimulus(5'h00, 1'b0, levelTable[t].card, levelTable[t].dep, levelTable[t].wd);
      runWatch(10);
      checkOutput($sformatf("levelCard%0d", t), cardInput, levelTable[t].expCard);
      checkOutput($sformatf("levelDeposit%0d", t), depositAmount, levelTable[t].expDep);
      checkOutput($sformatf("levelWithdraw%0d", t), withdrawAmount, levelTable[t].expWd);
    end
    applyStimulus(5'h00, 1'b0, 2'b00, 4'h0, 3'h0);
    runWatch(12);

    // Bouncing confirm, then a steady press
    bounceTotal = 0;
    for (int i = 0; i < 10; i++) begin
      btnConfirm = (i % 2 == 0);
      runWatch(2);
      bounceTotal += confPulses;
    end
    btnConfirm = 1'b1;
    runWatch(14);
    checkOutput("bounceNoEarlyPulse", bounceTotal, 0);
    checkOutput("bouncePulseCount", confPulses, 1);
    checkOutput("bouncePulseDelay", firstConf, 7);
    btnConfirm = 1'b0;
    runWatch(12);
    checkOutput("confirmReleaseNoPulse", confPulses, 0);
    btnConfirm = 1'b1;
    runWatch(12);
    checkOutput("confirmRepressPulse", confPulses, 1);
    checkOutput("confirmClickLength", clickCycles, expClick);
    btnConfirm = 1'b0;
    runWatch(12);

    // Menu priority and lock
    btnMenu = 5'b01010;
    runWatch(12);
    checkOutput("menuPriorityCount", menuPulses, 1);
    checkOutput("menuPriorityCode", lastMenu, 3'b010);
    btnMenu = 5'b01011;
    runWatch(12);
    checkOutput("menuLockedNoEvent", menuPulses, 0);
    btnMenu = 5'b00000;
    runWatch(12);
    checkOutput("menuReleaseNoEvent", menuPulses, 0);
    btnMenu = 5'b10000;
    runWatch(12);
    checkOutput("menuExitCount", menuPulses, 1);
    checkOutput("menuExitCode", lastMenu, 3'b101);
    btnMenu = 5'b00000;
    runWatch(12);

    // Menu and confirm together
    btnMenu = 5'b00100;
    btnConfirm = 1'b1;
    runWatch(12);
    checkOutput("jointMenuDelay", firstMenu, 7);
    checkOutput("jointConfirmDelay", firstConf, 7);
    checkOutput("jointMenuCode", lastMenu, 3'b011);
    checkOutput("jointClickLength", clickCycles, expClick);
    applyStimulus(5'h00, 1'b0, 2'b00, 4'h0, 3'h0);
    runWatch(12);

    // Deposit switch latency and glitch rejection
    swDeposit = 4'hA;
    firstDep = -1;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      if (firstDep < 0 && depositAmount == 4'hA) firstDep = i;
    end
    checkOutput("depositLatency", firstDep, 7);
    depBad = 0;
    swDeposit = 4'h0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (depositAmount != 4'hA) depBad++;
    end
    swDeposit = 4'hA;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (depositAmount != 4'hA) depBad++;
    end
    checkOutput("depositGlitchIgnored", depBad, 0);
    swDeposit = 4'h0;
    runWatch(12);

    // Reset in the middle of a confirm debounce
    btnConfirm = 1'b1;
    runWatch(2);
    preReset = confPulses;
    rst_n = 1'b0;
    runWatch(2);
    preReset += confPulses;
    rst_n = 1'b1;
    runWatch(12);
    checkOutput("resetMidDebounceNoPulse", preReset, 0);
    checkOutput("resetRedebounceCount", confPulses, 1);
    checkOutput("resetRedebounceDelay", firstConf, 7);
    btnConfirm = 1'b0;
    runWatch(12);

    // Reset while the menu is locked
    btnMenu = 5'b00001;
    runWatch(10);
    checkOutput("lockBeforeResetCount", menuPulses, 1);
    rst_n = 1'b0;
    runWatch(2);
    rst_n = 1'b1;
    runWatch(12);
    checkOutput("lockAfterResetCount", menuPulses, 1);
    checkOutput("lockAfterResetCode", lastMenu, 3'b001);
    btnMenu = 5'b00000;
    runWatch(12);

    // Randomized stimulus against the reference model
    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 5))
        0: btnMenu = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'b0;
        1: btnConfirm = ~btnConfirm;
        2: swCard = 2'($urandom);
        3: swDeposit = 4'($urandom);
        4: swWithdraw = 3'($urandom);
        default: if ($urandom_range(0, 9) == 0) rst_n = 1'b0;
      endcase
      runWatch($urandom_range(1, 8));
      rst_n = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
